// File: rtl/mc_cpu_pkg.sv
// Shared constants, state encodings and control bundle
// for the multi-cycle MIPS-subset core.
package mc_cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b111;
  localparam logic [2:0] ALU_ZERO = 3'b011;

  localparam logic [1:0] PC_ALU = 2'd0;
  localparam logic [1:0] PC_OUT = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;

  localparam logic [1:0] B_REG   = 2'd0;
  localparam logic [1:0] B_FOUR  = 2'd1;
  localparam logic [1:0] B_IMM   = 2'd2;
  localparam logic [1:0] B_IMMSH = 2'd3;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_WBMEM   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_WBALU   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  typedef struct packed {
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       dec_we;
    logic       a_sel;
    logic [1:0] b_sel;
    logic [2:0] alu_op;
    logic       aluout_we;
    logic       mdr_we;
    logic       rf_we;
    logic       rf_rd;
    logic       rf_mdr;
    logic       iord;
  } ctrl_t;

  function automatic logic [2:0] funct_to_alu(
    input logic [5:0] fn
  );
    case (fn)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// 32-bit ALU: add, sub, and, or, signed slt;
// any other code yields zero.
module alu
  import mc_cpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  ctrl,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = '0;
    case (ctrl)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {31'd0,
        $signed(a) < $signed(b)};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mc_cpu_ctrl.sv
// Multi-cycle control FSM with memory handshake,
// wait-state limit and sticky trap.
module mc_cpu_ctrl
  import mc_cpu_pkg::*;
#(
  parameter int ILLEGAL_TRAP = 0,
  parameter int WAIT_LIMIT   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  input  logic       zero,
  output ctrl_t      ctl,
  output logic       mem_read,
  output logic       mem_write,
  output logic       retire,
  output logic       trap,
  output logic [3:0] state_o
);

  localparam logic [15:0] WLIM =
    16'(WAIT_LIMIT - 1);

  state_t      state;
  logic [15:0] wcnt;
  logic        known;
  logic        wait_hit;

  always_comb begin
    known = 1'b0;
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
      OP_BNE, OP_J, OP_ADDI: known = 1'b1;
      default:               known = 1'b0;
    endcase
  end

  // abort on the last permitted wait cycle
  assign wait_hit = (WAIT_LIMIT > 0) &&
    !mem_ready && (wcnt == WLIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      wcnt  <= '0;
      trap  <= 1'b0;
    end else begin
      wcnt <= '0;
      unique case (state)
        S_FETCH, S_MEMRD, S_MEMWR: begin
          if (mem_ready) begin
            unique case (state)
              S_FETCH: state <= S_DECODE;
              S_MEMRD: state <= S_WBMEM;
              default: state <= S_FETCH;
            endcase
          end else if (wait_hit) begin
            state <= S_HALT;
            trap  <= 1'b1;
          end else begin
            wcnt <= wcnt + 16'd1;
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_RTYPE:      state <= S_EXEC;
            OP_LW, OP_SW:  state <= S_MEMADDR;
            OP_BEQ,
            OP_BNE:        state <= S_BRANCH;
            OP_J:          state <= S_JUMP;
            OP_ADDI:       state <= S_ADDIEX;
            default: begin
              if (ILLEGAL_TRAP != 0) begin
                state <= S_HALT;
                trap  <= 1'b1;
              end else begin
                state <= S_FETCH;
              end
            end
          endcase
        end
        S_MEMADDR:
          state <= (opcode == OP_LW) ?
            S_MEMRD : S_MEMWR;
        S_EXEC:   state <= S_WBALU;
        S_ADDIEX: state <= S_ADDIWB;
        S_WBMEM, S_WBALU, S_BRANCH,
        S_JUMP, S_ADDIWB:
          state <= S_FETCH;
        default:  state <= S_HALT;
      endcase
    end
  end

  always_comb begin
    ctl       = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    retire    = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_read   = 1'b1;
        ctl.ir_we  = mem_ready;
        ctl.pc_we  = mem_ready;
        ctl.pc_sel = PC_ALU;
        ctl.b_sel  = B_FOUR;
        ctl.alu_op = ALU_ADD;
      end
      S_DECODE: begin
        ctl.dec_we = 1'b1;
        ctl.b_sel  = B_IMMSH;
        ctl.alu_op = ALU_ADD;
        retire = !known && (ILLEGAL_TRAP == 0);
      end
      S_MEMADDR, S_ADDIEX: begin
        ctl.a_sel     = 1'b1;
        ctl.b_sel     = B_IMM;
        ctl.alu_op    = ALU_ADD;
        ctl.aluout_we = 1'b1;
      end
      S_MEMRD: begin
        mem_read   = 1'b1;
        ctl.iord   = 1'b1;
        ctl.mdr_we = mem_ready;
      end
      S_WBMEM: begin
        ctl.rf_we  = 1'b1;
        ctl.rf_mdr = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        ctl.iord  = 1'b1;
        retire    = mem_ready;
      end
      S_EXEC: begin
        ctl.a_sel     = 1'b1;
        ctl.b_sel     = B_REG;
        ctl.alu_op    = funct_to_alu(funct);
        ctl.aluout_we = 1'b1;
      end
      S_WBALU: begin
        ctl.rf_we = 1'b1;
        ctl.rf_rd = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        ctl.a_sel  = 1'b1;
        ctl.b_sel  = B_REG;
        ctl.alu_op = ALU_SUB;
        ctl.pc_sel = PC_OUT;
        ctl.pc_we  = zero ^ (opcode == OP_BNE);
        retire     = 1'b1;
      end
      S_JUMP: begin
        ctl.pc_sel = PC_JMP;
        ctl.pc_we  = 1'b1;
        retire     = 1'b1;
      end
      S_ADDIWB: begin
        ctl.rf_we = 1'b1;
        retire    = 1'b1;
      end
      default: ;
    endcase
    // requests drop as soon as reset asserts
    if (rst) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

  assign state_o = state;

endmodule

// File: rtl/multi_cycle_cpu_ctrl.sv
// Empty stub module kept for file-name stability.
// Control FSM lives in rtl/mc_cpu_ctrl.sv.
module multi_cycle_cpu_ctrl_unused;
endmodule

// File: rtl/regfiles.sv
// 32x32 register file, two async read ports,
// one write port; $0 is hardwired to zero.
module regfiles (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];

endmodule

// File: rtl/multi_cycle_cpu_hs.sv
// Multi-cycle MIPS-subset core top: datapath
// registers around alu, regfiles and mc_cpu_ctrl.
module multi_cycle_cpu_hs
  import mc_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          ILLEGAL_TRAP = 0,
  parameter int          WAIT_LIMIT   = 0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] Address,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Write_data,
  input  logic [31:0] Read_data,
  input  logic        Mem_ready,
  output logic        retire,
  output logic        trap,
  output logic [3:0]  state_o
);

  ctrl_t       ctl;
  logic [31:0] pc, ir, a_q, b_q;
  logic [31:0] aluout, mdr;
  logic [31:0] imm_ext, alu_a, alu_b;
  logic [31:0] alu_res, rd1, rd2, pc_next;
  logic        zero;

  assign imm_ext = {{16{ir[15]}}, ir[15:0]};
  assign alu_a   = ctl.a_sel ? a_q : pc;

  always_comb begin
    alu_b = b_q;
    case (ctl.b_sel)
      B_FOUR:  alu_b = 32'd4;
      B_IMM:   alu_b = imm_ext;
      B_IMMSH: alu_b = {imm_ext[29:0], 2'b00};
      default: alu_b = b_q;
    endcase
  end

  always_comb begin
    pc_next = alu_res;
    case (ctl.pc_sel)
      PC_OUT:  pc_next = aluout;
      PC_JMP:  pc_next = {pc[31:28],
                          ir[25:0], 2'b00};
      default: pc_next = alu_res;
    endcase
  end

  alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .ctrl   (ctl.alu_op),
    .result (alu_res),
    .zero   (zero)
  );

  regfiles u_rf (
    .clk (clk),
    .rst (rst),
    .we  (ctl.rf_we),
    .ra1 (ir[25:21]),
    .ra2 (ir[20:16]),
    .wa  (ctl.rf_rd ? ir[15:11] : ir[20:16]),
    .wd  (ctl.rf_mdr ? mdr : aluout),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  mc_cpu_ctrl #(
    .ILLEGAL_TRAP (ILLEGAL_TRAP),
    .WAIT_LIMIT   (WAIT_LIMIT)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .opcode    (ir[31:26]),
    .funct     (ir[5:0]),
    .mem_ready (Mem_ready),
    .zero      (zero),
    .ctl       (ctl),
    .mem_read  (MemRead),
    .mem_write (MemWrite),
    .retire    (retire),
    .trap      (trap),
    .state_o   (state_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      ir     <= '0;
      a_q    <= '0;
      b_q    <= '0;
      aluout <= '0;
      mdr    <= '0;
    end else begin
      if (ctl.ir_we) ir <= Read_data;
      if (ctl.pc_we) pc <= pc_next;
      if (ctl.dec_we) begin
        a_q <= rd1;
        b_q <= rd2;
      end
      // decode precomputes the branch target
      if (ctl.aluout_we || ctl.dec_we)
        aluout <= alu_res;
      if (ctl.mdr_we) mdr <= Read_data;
    end
  end

  assign Address    = ctl.iord ? aluout : pc;
  assign Write_data = b_q;

endmodule

// File: tb/tb_multi_cycle_cpu_hs.sv
// Directed bench: program vectors with latency,
// next-PC and register checks plus trap sequences.
module tb_multi_cycle_cpu_hs;

  typedef struct {
    int          stall;
    int          cyc;
    logic [31:0] npc;
    int          rn;
    logic [31:0] val;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst2 = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] Address, Write_data, Read_data;
  logic        MemRead, MemWrite, Mem_ready;
  logic        retire, trap;
  logic [3:0]  state_o;

  logic [31:0] Address2, Write_data2, Read_data2;
  logic        MemRead2, MemWrite2, Mem_ready2;
  logic        retire2, trap2;
  logic [3:0]  state2;

  logic [31:0] mem  [256];
  logic [31:0] mem2 [256];
  int n_run, n_fail;
  int wcnt, lim, fetch_stall, data_stall;
  bit mon_en;

  multi_cycle_cpu_hs #(
    .RESET_PC     (32'h100),
    .ILLEGAL_TRAP (1),
    .WAIT_LIMIT   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Address    (Address),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Write_data (Write_data),
    .Read_data  (Read_data),
    .Mem_ready  (Mem_ready),
    .retire     (retire),
    .trap       (trap),
    .state_o    (state_o)
  );

  multi_cycle_cpu_hs #(
    .RESET_PC     (32'h1000_0010),
    .ILLEGAL_TRAP (0),
    .WAIT_LIMIT   (0)
  ) dut2 (
    .clk        (clk),
    .rst        (rst2),
    .Address    (Address2),
    .MemRead    (MemRead2),
    .MemWrite   (MemWrite2),
    .Write_data (Write_data2),
    .Read_data  (Read_data2),
    .Mem_ready  (Mem_ready2),
    .retire     (retire2),
    .trap       (trap2),
    .state_o    (state2)
  );

  assign Read_data  = mem[Address[9:2]];
  assign Read_data2 = mem2[Address2[9:2]];
  assign Mem_ready2 = 1'b1;

  always_comb begin
    lim = (state_o == 4'd0) ?
      fetch_stall : data_stall;
    Mem_ready = (MemRead || MemWrite) &&
      (wcnt >= lim);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (!(MemRead || MemWrite) || Mem_ready)
      wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  always @(posedge clk)
    if (MemWrite && Mem_ready)
      mem[Address[9:2]] = Write_data;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && MemWrite && !Mem_ready) begin
      chk("sw_addr_hold", Address, 32'h8);
      chk("sw_data_hold", Write_data, 32'd12);
    end
    if (mon_en && MemRead && !Mem_ready &&
        state_o != 4'd0)
      chk("lw_addr_hold", Address, 32'h8);
  end

  task automatic wait_ret(input bit sel,
                          output int cyc);
    cyc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      cyc++;
      if ((sel ? retire2 : retire) == 1'b1)
        return;
    end
    cyc = -1;
  endtask

  logic [31:0] prog [21] = '{
    32'h20010005, 32'h20020007, 32'h00221820,
    32'h0022202A, 32'hAC030008, 32'h8C050008,
    32'h10210002, 32'h200B0077, 32'h200B0077,
    32'h14210002, 32'h00413022, 32'h00223824,
    32'h00224025, 32'h20000009, 32'h0022183F,
    32'h10220002, 32'h14220002, 32'h200B0077,
    32'h200B0077, 32'h200AFFFF, 32'hFC000000
  };

  vec_t vecs [16];
  int   cyc, cnt;

  initial begin
    n_run = 0;
    n_fail = 0;
    fetch_stall = 0;
    data_stall = 0;
    mon_en = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      mem2[i] = '0;
    end
    for (int i = 0; i < 21; i++)
      mem[64+i] = prog[i];
    mem2[4]  = 32'h08000040;
    mem2[64] = 32'hFC000000;
    mem2[65] = 32'hFC000000;

    vecs[0]  = '{0, 4, 32'h104, 1, 32'd5};
    vecs[1]  = '{0, 4, 32'h108, 2, 32'd7};
    vecs[2]  = '{0, 4, 32'h10C, 3, 32'd12};
    vecs[3]  = '{0, 4, 32'h110, 4, 32'd1};
    vecs[4]  = '{3, 7, 32'h114, 3, 32'd12};
    vecs[5]  = '{3, 8, 32'h118, 5, 32'd12};
    vecs[6]  = '{0, 3, 32'h124, 1, 32'd5};
    vecs[7]  = '{0, 3, 32'h128, 1, 32'd5};
    vecs[8]  = '{0, 4, 32'h12C, 6, 32'd2};
    vecs[9]  = '{0, 4, 32'h130, 7, 32'd5};
    vecs[10] = '{0, 4, 32'h134, 8, 32'd7};
    vecs[11] = '{0, 4, 32'h138, 0, 32'd0};
    vecs[12] = '{0, 4, 32'h13C, 3, 32'd0};
    vecs[13] = '{0, 3, 32'h140, 1, 32'd5};
    vecs[14] = '{0, 3, 32'h14C, 1, 32'd5};
    vecs[15] = '{0, 4, 32'h150, 10,
                 32'hFFFF_FFFF};

    @(negedge clk);
    chk("rst_addr", Address, 32'h100);
    chk("rst_memread", {31'd0, MemRead}, 0);
    chk("rst_trap", {31'd0, trap}, 0);
    chk("rst_state", {28'd0, state_o}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("fetch0_req", {31'd0, MemRead}, 1);
    chk("fetch0_addr", Address, 32'h100);

    for (int i = 0; i < 16; i++) begin
      data_stall = vecs[i].stall;
      mon_en = (vecs[i].stall > 0);
      wait_ret(1'b0, cyc);
      chk($sformatf("lat%0d", i), cyc,
          vecs[i].cyc);
      @(posedge clk);
      #1;
      chk($sformatf("npc%0d", i), Address,
          vecs[i].npc);
      chk($sformatf("reg%0d", i),
          dut.u_rf.regs[vecs[i].rn],
          vecs[i].val);
    end
    mon_en = 0;
    data_stall = 0;
    chk("mem_store", mem[2], 32'd12);
    chk("skipped_r11", dut.u_rf.regs[11], 0);

    repeat (3) @(negedge clk);
    chk("illegal_trap", {31'd0, trap}, 1);
    chk("illegal_halt", {28'd0, state_o}, 12);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (MemRead || MemWrite || retire) cnt++;
    end
    chk("halt_quiet", cnt, 0);
    chk("halt_pc", Address, 32'h154);

    fetch_stall = 100;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("stall_req", {31'd0, MemRead}, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_drop", {31'd0, MemRead}, 0);
    chk("rst_trap_clr", {31'd0, trap}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (trap) break;
      if (MemRead) cnt++;
    end
    chk("wl_trap", {31'd0, trap}, 1);
    chk("wl_cycles", cnt, 4);
    chk("wl_req_off", {31'd0, MemRead}, 0);
    chk("wl_state", {28'd0, state_o}, 12);

    @(posedge clk);
    #1 rst2 = 1'b0;
    #1;
    chk("j_fetch", Address2, 32'h1000_0010);
    wait_ret(1'b1, cyc);
    chk("j_lat", cyc, 3);
    @(posedge clk);
    #1;
    chk("j_target", Address2, 32'h1000_0100);
    wait_ret(1'b1, cyc);
    chk("nop_lat", cyc, 2);
    @(posedge clk);
    #1;
    chk("nop_npc", Address2, 32'h1000_0104);
    chk("nop_trap", {31'd0, trap2}, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_cycle_cpu_hs.md
Name: multi_cycle_cpu_hs

Overview:
Parametrised next-generation multi-cycle MIPS-subset core. It adds a ready-based memory handshake with wait states, a configurable reset vector, and extra instructions (addi, bne, j). It also adds an optional illegal-opcode trap and a retire pulse for verification. It instantiates the existing alu and regfiles blocks and sits between the testbench/system memory and nothing else.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ILLEGAL_TRAP, 0, 0: unknown opcode retires as NOP; 1: enter HALT and assert trap
WAIT_LIMIT, 0, 0: unlimited memory wait; N>0: abort access after N wait cycles and trap

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
Address  out  32  memory byte address (PC or ALUOut)
MemRead  out  1  read request, held until Mem_ready
MemWrite  out  1  write request, held until Mem_ready
Write_data  out  32  store data (B register)
Read_data  in  32  memory read data, valid when Mem_ready=1
Mem_ready  in  1  access completes in the cycle it is high while a request is asserted
retire  out  1  one-cycle pulse in the final cycle of each instruction
trap  out  1  sticky; high in HALT
state_o  out  4  current FSM state, debug

Behaviour:
- Reset (async): PC=RESET_PC; IR, A, B, ALUOut, MDR=0; state FETCH; MemRead=MemWrite=retire=trap=0; wait counter=0.
- States: FETCH0, DECODE1, MEMADDR2, MEMRD3, WBMEM4, MEMWR5, EXEC6, WBALU7, BRANCH8, JUMP9, ADDIEX10, ADDIWB11, HALT12.
- FETCH: MemRead=1, Address=PC. If Mem_ready=1: IR<=Read_data, PC<=PC+4, go to DECODE. Otherwise stay, with PC/IR unchanged.
- DECODE: A<=rf[rs], B<=rf[rt], ALUOut<=PC+(sext(imm)<<2). Next state by opcode: 000000 EXEC; 100011/101011 MEMADDR; 000100/000101 BRANCH; 000010 JUMP; 001000 ADDIEX. Any other opcode goes to HALT if ILLEGAL_TRAP, else retire=1 and FETCH.
- R-type funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Any other funct writes 0 to rd. A write to $0 is ignored (regfiles).
- EXEC: ALUOut<=A op B. WBALU: rd<=ALUOut, retire.
- MEMADDR: ALUOut<=A+sext(imm). lw goes to MEMRD; sw goes to MEMWR.
- MEMRD: MemRead=1, Address=ALUOut. On Mem_ready, MDR<=Read_data and go to WBMEM. WBMEM: rt<=MDR, retire.
- MEMWR: MemWrite=1, Address=ALUOut, Write_data=B. On Mem_ready, retire and go to FETCH. No register write.
- BRANCH: ALU computes A-B. beq taken if Zero; bne taken if !Zero. If taken, PC<=ALUOut. Retire and go to FETCH.
- JUMP: PC<={PC[31:28],IR[25:0],2'b00}. Retire and go to FETCH.
- ADDIEX: ALUOut<=A+sext(imm). ADDIWB: rt<=ALUOut, retire. Overflow is ignored (wraps).
- Zero-wait latency in cycles: R 4, lw 5, sw 4, beq/bne 3, j 3, addi 4. Each extra cycle with Mem_ready low adds one cycle.
- Request signals stay stable (Address, Write_data, MemRead/MemWrite) for every cycle until acceptance. Mem_ready is ignored when no request is asserted.
- Wait counter: clears on entry to each memory state. If WAIT_LIMIT>0 and the counter reaches WAIT_LIMIT without Mem_ready, the core deasserts the request, goes to HALT and sets trap.
- HALT: absorbing until reset. No memory requests, no register writes, PC frozen.
- Reset mid-access: requests drop asynchronously and the core restarts FETCH at RESET_PC.
- PC wraps modulo 2^32. Address is not alignment-checked; bits [1:0] pass through.

Decomposition:
- Package mc_cpu_pkg holds: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI); funct constants; 4-bit state encodings; ALU control codes (010 add, 110 sub, 000 and, 001 or, 111 slt).
- Sub-module mc_cpu_ctrl contains the FSM, control decode, wait counter and trap. The top holds the datapath registers and instantiates alu, regfiles and mc_cpu_ctrl.

Test Plan:
- Reset with RESET_PC=32'h100 -> first Address=0x100, MemRead=1, trap=0.
- Program: addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; slt $4,$1,$2, with Mem_ready tied high -> $3=12, $4=1, four retire pulses each 4 cycles apart.
- sw $3,8($0) then lw $5,8($0), with Mem_ready low for 3 cycles on each access -> Address/Write_data stable during the wait, $5=12, lw takes 8 cycles.
- beq $1,$1,+2 -> PC=branch_pc+4+8; bne $1,$1,+2 -> PC=branch_pc+4. Both take 3 cycles.
- j 0x40 at PC=0x1000_0010 -> next fetch Address=0x1000_0100.
- ILLEGAL_TRAP=1 with opcode 111111 -> HALT, trap=1, no further MemRead. WAIT_LIMIT=4 with Mem_ready held low -> trap after 4 wait cycles.
